// File: rtl/trng_cu_mc.sv
// TRNG control unit: sequences BIST, entropy accumulation and word hand-off
// across N_CH channels, retrying on health errors until a permanent DEAD state.
module trng_cu_mc #(
  parameter int N_CH       = 4,
  parameter int BIST_LEN   = 10,
  parameter int WAIT_CONST = 30,
  parameter int MAX_RETRY  = 7,
  parameter int RW         = $clog2(MAX_RETRY+1)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            enable_i,
  input  logic            disable_i,
  input  logic [N_CH-1:0] ch_en_i,
  input  logic [N_CH-1:0] error_i,
  input  logic            ack_read_i,
  input  logic            tot_fail_i,
  output logic            enable_ht_o,
  output logic            dff_en_o,
  output logic            flush_regs_o,
  output logic            rnd_ready_o,
  output logic            trng_intr_o,
  output logic            dead_o,
  output logic [RW-1:0]   retry_cnt_o,
  output logic [2:0]      state_o
);

  localparam int BW = (BIST_LEN   > 1) ? $clog2(BIST_LEN)   : 1;
  localparam int WW = (WAIT_CONST > 1) ? $clog2(WAIT_CONST) : 1;
  localparam logic [BW-1:0] BIST_LAST = BW'(BIST_LEN - 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(WAIT_CONST - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_BIST = 3'd1, S_WAIT = 3'd2,
    S_READY = 3'd3, S_WACK = 3'd4, S_DEAD = 3'd5
  } state_t;

  state_t        r_state;
  logic [BW-1:0] r_bist;
  logic [WW-1:0] r_wait;
  logic [RW-1:0] r_retry;

  state_t        w_nxt;
  logic [BW-1:0] w_bist_n;
  logic [WW-1:0] w_wait_n;
  logic [RW-1:0] w_retry_n;
  logic [RW-1:0] w_rinc;
  logic          w_flush_ack_n;
  logic          w_err;
  logic          w_ch_any;

  assign w_err    = |(error_i & ch_en_i);
  assign w_ch_any = |ch_en_i;
  assign w_rinc   = (r_retry == RETRY_MAX) ? RETRY_MAX : r_retry + 1'b1;

  always_comb begin
    w_nxt         = r_state;
    w_bist_n      = '0;
    w_wait_n      = '0;
    w_retry_n     = r_retry;
    w_flush_ack_n = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_retry_n = '0;
        if (enable_i && w_ch_any) w_nxt = S_BIST;
      end
      S_DEAD: ;
      default: begin
        if (tot_fail_i) begin
          w_nxt = S_DEAD;
        end else if (disable_i || !w_ch_any) begin
          w_nxt     = S_IDLE;
          w_retry_n = '0;
        end else if (w_err) begin
          w_retry_n = w_rinc;
          w_nxt     = (w_rinc == RETRY_MAX) ? S_DEAD : S_BIST;
        end else begin
          case (r_state)
            S_BIST: begin
              if (r_bist == BIST_LAST) w_nxt = S_WAIT;
              else w_bist_n = r_bist + 1'b1;
            end
            S_WAIT: begin
              if (r_wait == WAIT_LAST) begin
                w_nxt     = S_READY;
                w_retry_n = '0;
              end else begin
                w_wait_n = r_wait + 1'b1;
              end
            end
            S_READY: w_nxt = S_WACK;
            S_WACK: begin
              if (ack_read_i) begin
                w_nxt         = S_WAIT;
                w_flush_ack_n = 1'b1;
              end
            end
            default: w_nxt = S_IDLE;
          endcase
        end
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with r_state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state      <= S_IDLE;
      r_bist       <= '0;
      r_wait       <= '0;
      r_retry      <= '0;
      enable_ht_o  <= 1'b0;
      dff_en_o     <= 1'b0;
      flush_regs_o <= 1'b0;
      rnd_ready_o  <= 1'b0;
      trng_intr_o  <= 1'b0;
      dead_o       <= 1'b0;
    end else begin
      r_state      <= w_nxt;
      r_bist       <= w_bist_n;
      r_wait       <= w_wait_n;
      r_retry      <= w_retry_n;
      enable_ht_o  <= (w_nxt inside {S_BIST, S_WAIT, S_READY, S_WACK});
      dff_en_o     <= (w_nxt inside {S_BIST, S_WAIT, S_READY, S_WACK});
      flush_regs_o <= (w_nxt inside {S_BIST, S_DEAD}) || w_flush_ack_n;
      rnd_ready_o  <= (w_nxt inside {S_READY, S_WACK});
      trng_intr_o  <= (w_nxt inside {S_READY, S_DEAD});
      dead_o       <= (w_nxt == S_DEAD);
    end
  end

  assign retry_cnt_o = r_retry;
  assign state_o     = r_state;

endmodule

// File: tb/tb_trng_cu_mc.sv
// Directed bench for trng_cu_mc with default parameters.
module tb_trng_cu_mc;
  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       enable_i = 1'b0, disable_i = 1'b0, ack_read_i = 1'b0, tot_fail_i = 1'b0;
  logic [3:0] ch_en_i = 4'h0, error_i = 4'h0;
  logic       enable_ht_o, dff_en_o, flush_regs_o, rnd_ready_o, trng_intr_o, dead_o;
  logic [2:0] retry_cnt_o;
  logic [2:0] state_o;
  int n_chk = 0, n_err = 0;

  trng_cu_mc dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .enable_i(enable_i), .disable_i(disable_i),
    .ch_en_i(ch_en_i), .error_i(error_i), .ack_read_i(ack_read_i), .tot_fail_i(tot_fail_i),
    .enable_ht_o(enable_ht_o), .dff_en_o(dff_en_o), .flush_regs_o(flush_regs_o),
    .rnd_ready_o(rnd_ready_o), .trng_intr_o(trng_intr_o), .dead_o(dead_o),
    .retry_cnt_o(retry_cnt_o), .state_o(state_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  // Outputs packed as {ht,dff,flush,rdy,intr,dead}.
  function automatic int outs();
    return {enable_ht_o, dff_en_o, flush_regs_o, rnd_ready_o, trng_intr_o, dead_o};
  endfunction

  task automatic pulse_enable();
    enable_i = 1'b1; step(1); enable_i = 1'b0;
  endtask

  task automatic do_reset();
    #2 rst_ni = 1'b0; #2 rst_ni = 1'b1; step(1);
  endtask

  initial begin
    #3;
    chk("rst_state", state_o, 0);
    chk("rst_outs", outs(), 0);
    chk("rst_retry", retry_cnt_o, 0);
    rst_ni = 1'b1;
    step(1);

    // No channels enabled: enable ignored
    pulse_enable();
    chk("en_no_ch", state_o, 0);

    // Nominal bring-up
    ch_en_i = 4'hF;
    pulse_enable();                       // edge 0
    chk("bist_entry", state_o, 1);
    chk("bist_outs", outs(), 6'b111000);
    step(9);                              // edge 9
    chk("bist_last", state_o, 1);
    step(1);                              // edge 10
    chk("wait_entry", state_o, 2);
    chk("wait_outs", outs(), 6'b110000);
    step(29);                             // edge 39
    chk("wait_last", state_o, 2);
    step(1);                              // edge 40
    chk("ready_state", state_o, 3);
    chk("ready_outs", outs(), 6'b110110);
    step(1);                              // edge 41
    chk("wack_state", state_o, 4);
    chk("wack_outs", outs(), 6'b110100);
    step(5);
    chk("wack_hold", state_o, 4);

    // Ack alone: flush one cycle, next word 30 cycles later
    ack_read_i = 1'b1; step(1); ack_read_i = 1'b0;
    chk("ack_wait", state_o, 2);
    chk("ack_flush", flush_regs_o, 1);
    step(1);
    chk("ack_flush_off", flush_regs_o, 0);
    step(28);
    chk("ack_wait_last", state_o, 2);
    step(1);
    chk("word2_ready", state_o, 3);
    chk("word2_intr", trng_intr_o, 1);
    step(1);
    chk("word2_wack", state_o, 4);

    // Ack plus error: error handling wins
    ack_read_i = 1'b1; error_i = 4'h1; step(1);
    ack_read_i = 1'b0; error_i = 4'h0;
    chk("ackerr_state", state_o, 1);
    chk("ackerr_retry", retry_cnt_o, 1);
    step(10);
    chk("retry_wait", state_o, 2);
    step(30);
    chk("retry_ready", state_o, 3);
    chk("retry_clear", retry_cnt_o, 0);
    step(1);

    // Disable in WAIT_ACK
    disable_i = 1'b1; step(1); disable_i = 1'b0;
    chk("dis_state", state_o, 0);
    chk("dis_outs", outs(), 0);

    // Masked channel errors ignored; enabled-channel error restarts BIST
    ch_en_i = 4'b0111;
    pulse_enable();
    error_i = 4'b1000; step(3);
    chk("mask_state", state_o, 1);
    chk("mask_retry", retry_cnt_o, 0);
    error_i = 4'b0000; step(1);
    error_i = 4'b0001; step(1); error_i = 4'b0000;
    chk("err_bist", state_o, 1);
    chk("err_retry", retry_cnt_o, 1);
    step(9);
    chk("err_bist_full", state_o, 1);
    step(1);
    chk("err_to_wait", state_o, 2);

    // Fatal failure in WAIT
    tot_fail_i = 1'b1; step(1); tot_fail_i = 1'b0;
    chk("tf_dead", state_o, 5);
    chk("tf_outs", outs(), 6'b001011);
    do_reset();
    chk("tf_rst", state_o, 0);
    tot_fail_i = 1'b1; step(2); tot_fail_i = 1'b0;
    chk("tf_idle", state_o, 0);

    // Seven consecutive errors -> DEAD
    ch_en_i = 4'hF;
    pulse_enable();
    error_i = 4'h1; step(6);
    chk("err6_state", state_o, 1);
    chk("err6_retry", retry_cnt_o, 6);
    step(1); error_i = 4'h0;
    chk("err7_dead", state_o, 5);
    chk("err7_outs", outs(), 6'b001011);
    chk("err7_retry", retry_cnt_o, 7);
    enable_i = 1'b1; disable_i = 1'b1; ack_read_i = 1'b1; step(2);
    enable_i = 1'b0; disable_i = 1'b0; ack_read_i = 1'b0;
    chk("dead_sticky", state_o, 5);
    rst_ni = 1'b0; #2;
    chk("dead_async_rst", state_o, 0);
    chk("dead_async_outs", outs(), 0);
    rst_ni = 1'b1; step(1);

    // Async reset in WAIT_ACK
    pulse_enable(); step(10); step(30); step(1);
    chk("pre_rst_rdy", rnd_ready_o, 1);
    chk("pre_rst_state", state_o, 4);
    rst_ni = 1'b0; #2;
    chk("arst_rdy", rnd_ready_o, 0);
    chk("arst_state", state_o, 0);
    chk("arst_retry", retry_cnt_o, 0);
    #1 rst_ni = 1'b1; step(2);
    chk("post_rst_outs", outs(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
